mem_port_arbiter: RTL and testbench

Arbitrates the core's single memory port between the instruction-fetch requester and the execute-stage data requester (loads/stores).
- Data accesses have priority over fetches.
- A streak limiter prevents fetch starvation.
- The block drives `stall_o` into the pipeline stages' `stall_i` while a data access is pending or in flight.
- Sits between the fetch/execute stages and the memory wrapper; all memory-side signals are registered.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins arbitration unless a waiting fetch has been passed over MAX_DM_STREAK times.
module mem_port_arbiter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [15:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [TW-1:0] T_LAST     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            T_EN       = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

  state_t          r_state, w_next;
  logic [SW-1:0]   r_streak;
  logic [TW-1:0]   r_tcnt;
  logic            r_flushed, r_hsel, r_err;
  logic            r_if_gnt, r_dm_gnt, r_if_rvalid, r_dm_rvalid;
  logic [15:0]     r_if_rdata;
  logic [31:0]     r_dm_rdata;
  logic            r_mem_req, r_mem_we;
  logic [3:0]      r_mem_be;
  logic [31:0]     r_mem_addr, r_mem_wdata;

  logic            w_streak_hit, w_dm_start, w_if_start, w_busy;
  logic            w_done, w_abort, w_end;
  logic            w_if_rvalid_d, w_dm_rvalid_d;
  logic [15:0]     w_if_rdata_d;
  logic [31:0]     w_dm_rdata_d;
  logic            w_unused;

  assign w_unused = ^{if_addr_i[0], dm_addr_i[1:0]};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dm_start)      w_next = DM_WAIT;
        else if (w_if_start) w_next = IF_WAIT;
      end
      IF_WAIT, DM_WAIT: if (w_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Arbitration decode and response values registered at the next edge
  always_comb begin
    w_streak_hit  = (r_streak == STREAK_MAX) && if_req_i;
    w_busy        = (r_state != IDLE);
    w_dm_start    = (r_state == IDLE) && dm_req_i && !w_streak_hit;
    w_if_start    = (r_state == IDLE) && if_req_i && (!dm_req_i || w_streak_hit);
    w_done        = w_busy && mem_ready_i;
    // Ready in the same cycle as the last allowed wait cycle counts as completion.
    w_abort       = T_EN && w_busy && !mem_ready_i && (r_tcnt == T_LAST);
    w_end         = w_done || w_abort;
    w_if_rvalid_d = (r_state == IF_WAIT) && w_end && !(r_flushed || if_flush_i);
    w_dm_rvalid_d = (r_state == DM_WAIT) && w_end;
    w_if_rdata_d  = 16'h0;
    w_dm_rdata_d  = 32'h0;
    if ((r_state == IF_WAIT) && w_done)
      w_if_rdata_d = r_hsel ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    if ((r_state == DM_WAIT) && w_done && !r_mem_we)
      w_dm_rdata_d = mem_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_streak    <= '0;
      r_tcnt      <= '0;
      r_flushed   <= 1'b0;
      r_hsel      <= 1'b0;
      r_err       <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_gnt    <= w_if_start;
      r_dm_gnt    <= w_dm_start;
      r_if_rvalid <= w_if_rvalid_d;
      r_dm_rvalid <= w_dm_rvalid_d;
      r_if_rdata  <= w_if_rdata_d;
      r_dm_rdata  <= w_dm_rdata_d;
      if (w_abort) r_err <= 1'b1;

      if (!if_req_i || w_if_start)                  r_streak <= '0;
      else if (w_dm_start && r_streak != STREAK_MAX) r_streak <= r_streak + SW'(1);

      if (!w_busy)                                      r_tcnt <= '0;
      else if (T_EN && !mem_ready_i && !w_abort)        r_tcnt <= r_tcnt + TW'(1);

      if (w_if_start)                               r_flushed <= 1'b0;
      else if ((r_state == IF_WAIT) && if_flush_i)  r_flushed <= 1'b1;

      if (w_dm_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_we_i;
        r_mem_be    <= dm_be_i;
        r_mem_addr  <= {dm_addr_i[31:2], 2'b00};
        r_mem_wdata <= dm_wdata_i;
      end else if (w_if_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_be    <= 4'hF;
        r_mem_addr  <= {if_addr_i[31:2], 2'b00};
        r_mem_wdata <= 32'h0;
        r_hsel      <= if_addr_i[1];
      end else if (w_end) begin
        r_mem_req   <= 1'b0;
      end
    end
  end

  assign stall_o     = dm_req_i | (r_state == DM_WAIT);
  assign if_gnt_o    = r_if_gnt;
  assign dm_gnt_o    = r_dm_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign dm_rvalid_o = r_dm_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign err_o       = r_err;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 0, if_flush = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0]  dm_be = 0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, stall, err;
  logic        mem_req, mem_we;
  logic [15:0] if_rdata;
  logic [31:0] dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0, errors = 0;

  mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
    .dm_rdata_o(dm_rdata), .stall_o(stall), .err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the randomized phase
  int          m_own, m_wait, m_streak;
  logic        m_flushed, m_hsel, m_we, m_err, fin, abt;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_mem_req;
  logic [15:0] e_if_rd;
  logic [31:0] e_dm_rd;
  string       gseq;
  int          ng;

  initial begin
    // ---- reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_gnts", 32'({if_gnt, dm_gnt}), 0);
    chk("rst_rvalids", 32'({if_rvalid, dm_rvalid}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick(); tick();
    rst = 1'b0;

    // ---- fetch alone, zero-wait
    if_req = 1; if_addr = 32'h102;
    tick();
    chk("f_gnt", 32'(if_gnt), 1);
    chk("f_mem_req", 32'(mem_req), 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we_be", 32'({mem_we, mem_be}), 32'h0F);
    if_req = 0; mem_ready = 1; mem_rdata = 32'hBEEF1234;
    tick();
    chk("f_rvalid", 32'(if_rvalid), 1);
    chk("f_rdata", 32'(if_rdata), 32'hBEEF);
    chk("f_mem_req_drop", 32'(mem_req), 0);
    mem_ready = 0;

    // ---- store with two wait cycles
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'hAA55;
    mem_rdata = 32'h12345678;
    #1 chk("s_stall_n", 32'(stall), 1);
    tick();
    chk("s_gnt", 32'(dm_gnt), 1);
    dm_req = 0;
    for (int i = 1; i <= 3; i++) begin
      chk("s_mem_req", 32'(mem_req), 1);
      chk("s_mem_we_be", 32'({mem_we, mem_be}), 32'h13);
      chk("s_mem_addr", mem_addr, 32'h200);
      chk("s_mem_wdata", mem_wdata, 32'hAA55);
      #1 chk("s_stall", 32'(stall), 1);
      if (i == 3) mem_ready = 1;
      tick();
    end
    chk("s_rvalid", 32'(dm_rvalid), 1);
    chk("s_rdata", dm_rdata, 0);
    mem_ready = 0;
    #1 chk("s_stall_end", 32'(stall), 0);

    // ---- both requesters held continuously: streak limiter
    if_req = 1; if_addr = 32'h500; dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    gseq = ""; ng = 0;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      tick();
      if (dm_gnt) begin gseq = {gseq, "D"}; ng++; end
      if (if_gnt) begin gseq = {gseq, "F"}; ng++; end
      dm_req = !dm_gnt; if_req = !if_gnt; mem_ready = mem_req;
    end
    checks++;
    assert (gseq == "DDDDFDDDDF") else begin
      errors++;
      $error("FAIL streak_seq observed=%s expected=DDDDFDDDDF", gseq);
    end
    dm_req = 0; if_req = 0; mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();

    // ---- flushed fetch, next queued fetch served normally
    if_req = 1; if_addr = 32'h40;
    tick();
    chk("fl_gnt", 32'(if_gnt), 1);
    if_req = 0;
    tick();
    if_flush = 1; if_req = 1; if_addr = 32'h44;
    tick();
    if_flush = 0;
    tick();
    mem_ready = 1; mem_rdata = 32'h99998888;
    tick();
    chk("fl_no_rvalid", 32'(if_rvalid), 0);
    mem_ready = 0;
    tick();
    chk("fl_next_gnt", 32'(if_gnt), 1);
    chk("fl_next_addr", mem_addr, 32'h44);
    if_req = 0; mem_ready = 1; mem_rdata = 32'h11112222;
    tick();
    chk("fl_next_rvalid", 32'(if_rvalid), 1);
    chk("fl_next_rdata", 32'(if_rdata), 32'h2222);
    mem_ready = 0;

    // ---- ready on the last allowed wait cycle wins over timeout
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    tick();
    dm_req = 0;
    for (int i = 2; i <= 8; i++) tick();
    mem_ready = 1; mem_rdata = 32'h5A5A0001;
    tick();
    mem_ready = 0;
    chk("rw_rvalid", 32'(dm_rvalid), 1);
    chk("rw_rdata", dm_rdata, 32'h5A5A0001);
    chk("rw_err", 32'(err), 0);

    // ---- timeout on a load
    dm_req = 1; dm_addr = 32'h304; mem_rdata = 32'hFFFFFFFF;
    tick();
    dm_req = 0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("to_mem_req_held", 32'(mem_req), 1);
    end
    tick();
    chk("to_mem_req_drop", 32'(mem_req), 0);
    chk("to_rvalid", 32'(dm_rvalid), 1);
    chk("to_rdata", dm_rdata, 0);
    chk("to_err", 32'(err), 1);
    dm_req = 1; dm_addr = 32'h308;
    tick();
    chk("to_err_sticky", 32'(err), 1);
    chk("to_next_gnt", 32'(dm_gnt), 1);
    dm_req = 0; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ready = 0;
    chk("to_next_rdata", dm_rdata, 32'hCAFEF00D);
    chk("to_next_rvalid", 32'(dm_rvalid), 1);

    // ---- reset in the middle of a data access
    dm_req = 1; dm_addr = 32'h30C;
    tick();
    dm_req = 0;
    tick();
    rst = 1;
    #1;
    chk("rm_mem_req", 32'(mem_req), 0);
    chk("rm_err", 32'(err), 0);
    chk("rm_outs", 32'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, stall}), 0);
    tick();
    rst = 0;
    tick();
    chk("rm_no_rvalid", 32'(dm_rvalid), 0);
    if_req = 1; if_addr = 32'h600;
    tick();
    chk("rm_fetch_gnt", 32'(if_gnt), 1);
    if_req = 0; mem_ready = 1;
    tick();
    mem_ready = 0;

    // ---- randomized run against the model
    rst = 1;
    tick();
    rst = 0;
    m_own = 0; m_wait = 0; m_streak = 0; m_err = 0; m_flushed = 0; m_hsel = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_mem_req = 0;
    e_if_rd = 0; e_dm_rd = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("r_if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("r_dm_gnt", 32'(dm_gnt), 32'(e_dm_gnt));
      chk("r_if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("r_dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
      chk("r_mem_req", 32'(mem_req), 32'(e_mem_req));
      chk("r_err", 32'(err), 32'(m_err));
      if (e_if_rv) chk("r_if_rdata", 32'(if_rdata), 32'(e_if_rd));
      if (e_dm_rv) chk("r_dm_rdata", dm_rdata, e_dm_rd);
      if (e_mem_req) begin
        chk("r_mem_addr", mem_addr, m_addr);
        chk("r_mem_we_be", 32'({mem_we, mem_be}), 32'({m_we, m_be}));
        if (m_own == 2) chk("r_mem_wdata", mem_wdata, m_wdata);
      end

      if (e_if_gnt) if_req = 0;
      else if (!if_req && $urandom_range(1, 0) == 1) begin
        if_req = 1; if_addr = $urandom & ~32'h1;
      end
      if (e_dm_gnt) dm_req = 0;
      else if (!dm_req && $urandom_range(1, 0) == 1) begin
        dm_req = 1; dm_we = 1'($urandom); dm_be = 4'($urandom);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      if_flush  = ($urandom_range(7, 0) == 0);
      mem_ready = ($urandom_range(2, 0) == 0);
      mem_rdata = $urandom;
      #1 chk("r_stall", 32'(stall), 32'(dm_req | (m_own == 2)));

      e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_if_rd = 0; e_dm_rd = 0;
      if (m_own == 0) begin
        if (dm_req && !(m_streak == MAXS && if_req)) begin
          m_own = 2; e_dm_gnt = 1; m_wait = 0;
          m_addr = {dm_addr[31:2], 2'b00}; m_we = dm_we; m_be = dm_be; m_wdata = dm_wdata;
        end else if (if_req) begin
          m_own = 1; e_if_gnt = 1; m_wait = 0; m_flushed = 0;
          m_addr = {if_addr[31:2], 2'b00}; m_we = 0; m_be = 4'hF; m_hsel = if_addr[1];
        end
        if (!if_req || e_if_gnt) m_streak = 0;
        else if (e_dm_gnt && m_streak < MAXS) m_streak++;
      end else begin
        if (!if_req) m_streak = 0;
        if (m_own == 1 && if_flush) m_flushed = 1;
        fin = 0; abt = 0;
        if (mem_ready) fin = 1;
        else begin
          m_wait++;
          if (m_wait == TO) begin fin = 1; abt = 1; end
        end
        if (fin) begin
          if (m_own == 1) begin
            e_if_rv = !m_flushed;
            e_if_rd = abt ? 16'h0 : (m_hsel ? mem_rdata[31:16] : mem_rdata[15:0]);
          end else begin
            e_dm_rv = 1;
            e_dm_rd = (abt || m_we) ? 32'h0 : mem_rdata;
          end
          if (abt) m_err = 1;
          m_own = 0;
        end
      end
      e_mem_req = (m_own != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
